mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 6, memory address width.
REQ-002 Parameter DATA_W, default 8, memory data width.
REQ-003 Parameter WAIT_CYCLES, default 2, extra memory wait states, legal range 0..7.
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 reset  in  1  synchronous, active-low reset.
REQ-006 cpu_req  in  1  CPU controller access request; held high until cpu_ack.
REQ-007 cpu_we  in  1  CPU access is write (1) or read (0).
REQ-008 cpu_addr  in  ADDR_W  CPU access address.
REQ-009 cpu_wdata  in  DATA_W  CPU write data.
REQ-010 ldr_req, ldr_we, ldr_addr, ldr_wdata  in  1/1/ADDR_W/DATA_W  program-loader port, same semantics as the CPU port.
REQ-011 cpu_ack, ldr_ack  out  1  one-cycle completion pulse to the granted requester.
REQ-012 rdata  out  DATA_W  registered read data, valid in the ack cycle and held until the next capture.
REQ-013 mem_rd, mem_wr  out  1  memory read and write strobes.
REQ-014 mem_addr, mem_wdata  out  ADDR_W/DATA_W  latched address and write data to memory.
REQ-015 mem_rdata  in  DATA_W  memory read data, sampled on the final access cycle.
REQ-016 busy  out  1  high in ACCESS and DONE.
REQ-017 gnt_cpu, gnt_ldr  out  1  current grant owner, one-hot or both low.

Function
REQ-018 FSM states: IDLE, ACCESS, DONE.
REQ-019 IDLE with any req high: select requester, latch its we/addr/wdata, set wait counter to 0, go to ACCESS on the next edge.
REQ-020 Arbitration is round-robin: with both requests high, grant the port not granted last; with one request high, grant that port.
REQ-021 ACCESS: drive mem_addr/mem_wdata from the latches; assert mem_rd when latched we=0 and mem_wr when latched we=1; increment the counter each cycle.
REQ-022 ACCESS lasts exactly WAIT_CYCLES+1 cycles; on its last cycle, capture mem_rdata into rdata (reads only) and go to DONE.
REQ-023 DONE lasts one cycle: pulse the granted port's ack, deassert the memory strobes, update last_grant, go to IDLE.
REQ-024 Latency: request sampled at edge N gives ack high in cycle N+WAIT_CYCLES+2.
REQ-025 The requester drops req on the edge where ack is sampled; a req still high in IDLE is treated as a new request.
REQ-026 Requests arriving during ACCESS/DONE wait; an ungranted req is never dropped and is never acked spuriously.
REQ-027 Changes to the granted port's inputs after latching have no effect on the access in progress.
REQ-028 mem_rd and mem_wr are never high together and are low outside ACCESS.
REQ-029 Writes leave rdata unchanged.
REQ-030 WAIT_CYCLES=0: ACCESS is a single cycle.

Reset
REQ-031 reset low at an edge forces: state=IDLE, counter=0, all strobes/acks/grants/busy=0, rdata=0, address/data latches=0, last_grant=loader (so the CPU wins the first tie).
REQ-032 Reset during ACCESS or DONE aborts the access: no ack is issued and strobes are low from the next cycle.

Structure
REQ-033 Shared package tiny_risc_pkg holds the FSM state enumeration, the default ADDR_W/DATA_W constants and the grant encoding.
REQ-034 One sub-module, rr_arb2: two-request round-robin grant logic with last_grant input, purely combinational; the FSM lives in mem_arbiter.

Verification
REQ-035 CPU read, WAIT_CYCLES=2: cpu_req=1, cpu_addr=0x05, mem_rdata=0xA3 -> mem_rd high for 3 cycles, cpu_ack high 4 cycles after the request edge, rdata=0xA3.
REQ-036 Loader write: ldr_we=1, addr=0x3F, wdata=0x5C -> mem_wr high 3 cycles with mem_addr=0x3F and mem_wdata=0x5C; ldr_ack pulses once; rdata unchanged.
REQ-037 Simultaneous cpu_req and ldr_req, both held, right after reset -> CPU served first, then the loader, then the CPU again (alternating).
REQ-038 cpu_addr changed from 0x05 to 0x10 mid-ACCESS -> mem_addr stays 0x05 for the whole access.
REQ-039 reset driven low in the second ACCESS cycle -> strobes low next cycle, no ack, state IDLE; a new request is served normally.
REQ-040 WAIT_CYCLES=0 build: read -> mem_rd high 1 cycle, ack 2 cycles after the request edge; assert mem_rd&mem_wr is never true in any test.

Source files
------------

// File: rtl/tiny_risc_pkg.sv
// Shared definitions for the tiny RISC memory subsystem: arbiter FSM states,
// default bus widths and the grant-owner encoding.
package tiny_risc_pkg;

    localparam int ADDR_W_DEF = 6;
    localparam int DATA_W_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } arb_state_t;

    typedef enum logic {
        GNT_CPU = 1'b0,
        GNT_LDR = 1'b1
    } grant_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin grant: on a tie the port that did not win last
// time is chosen; a lone request always wins.
module rr_arb2
    import tiny_risc_pkg::*;
(
    input  logic   cpu_req,
    input  logic   ldr_req,
    input  grant_t last_grant,
    output logic   gnt_cpu,
    output logic   gnt_ldr,
    output grant_t winner
);

    always_comb begin
        gnt_cpu = cpu_req && (!ldr_req || (last_grant == GNT_LDR));
        gnt_ldr = ldr_req && !gnt_cpu;
        winner  = gnt_ldr ? GNT_LDR : GNT_CPU;
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates a single-port memory between the CPU and the program loader,
// running one access at a time through IDLE -> ACCESS -> DONE.
module mem_arbiter
    import tiny_risc_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic              ldr_req,
    input  logic              ldr_we,
    input  logic [ADDR_W-1:0] ldr_addr,
    input  logic [DATA_W-1:0] ldr_wdata,
    output logic              cpu_ack,
    output logic              ldr_ack,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              gnt_cpu,
    output logic              gnt_ldr
);

    localparam logic [2:0] LAST_CNT = 3'(WAIT_CYCLES);

    arb_state_t        state;
    grant_t            last_grant;
    grant_t            cur_gnt;
    logic [2:0]        cnt;
    logic              lat_we;

    logic              arb_cpu;
    logic              arb_ldr;
    grant_t            arb_winner;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    rr_arb2 u_rr_arb2 (
        .cpu_req    (cpu_req),
        .ldr_req    (ldr_req),
        .last_grant (last_grant),
        .gnt_cpu    (arb_cpu),
        .gnt_ldr    (arb_ldr),
        .winner     (arb_winner)
    );

    always_comb begin
        sel_we    = arb_ldr ? ldr_we    : cpu_we;
        sel_addr  = arb_ldr ? ldr_addr  : cpu_addr;
        sel_wdata = arb_ldr ? ldr_wdata : cpu_wdata;
    end

    // mem_addr/mem_wdata double as the request latches, so later changes on
    // the requester's inputs cannot reach the access in progress.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= ST_IDLE;
            cnt        <= 3'd0;
            lat_we     <= 1'b0;
            cur_gnt    <= GNT_CPU;
            last_grant <= GNT_LDR;
            cpu_ack    <= 1'b0;
            ldr_ack    <= 1'b0;
            rdata      <= '0;
            mem_rd     <= 1'b0;
            mem_wr     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            busy       <= 1'b0;
            gnt_cpu    <= 1'b0;
            gnt_ldr    <= 1'b0;
        end else begin
            cpu_ack <= 1'b0;
            ldr_ack <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (arb_cpu || arb_ldr) begin
                        state     <= ST_ACCESS;
                        cnt       <= 3'd0;
                        cur_gnt   <= arb_winner;
                        gnt_cpu   <= arb_cpu;
                        gnt_ldr   <= arb_ldr;
                        busy      <= 1'b1;
                        lat_we    <= sel_we;
                        mem_addr  <= sel_addr;
                        mem_wdata <= sel_wdata;
                        mem_rd    <= !sel_we;
                        mem_wr    <= sel_we;
                    end
                end
                ST_ACCESS: begin
                    cnt <= cnt + 3'd1;
                    if (cnt == LAST_CNT) begin
                        state   <= ST_DONE;
                        mem_rd  <= 1'b0;
                        mem_wr  <= 1'b0;
                        cpu_ack <= (cur_gnt == GNT_CPU);
                        ldr_ack <= (cur_gnt == GNT_LDR);
                        if (!lat_we) begin
                            rdata <= mem_rdata;
                        end
                    end
                end
                ST_DONE: begin
                    state      <= ST_IDLE;
                    cnt        <= 3'd0;
                    last_grant <= cur_gnt;
                    busy       <= 1'b0;
                    gnt_cpu    <= 1'b0;
                    gnt_ldr    <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
